// File: rtl/hf_seq_pkg.sv
// rtl/hf_seq_pkg.sv - shared types and helpers for the hazard-free function sequencer
//
// Purpose : FSM state encoding, default expected truth table, Gray-code helper
//           and synchronizer depth used by hf_func_sequencer.
// Ports   : none (package)

package hf_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } hf_state_e;

  // bit i = F for {A,B,C,D} = i, A is the MSB
  localparam logic [15:0] HF_EXP_TT_DEFAULT = 16'h3F75;

  localparam int HF_SYNC_STAGES = 2;

  function automatic logic [3:0] gray4(input logic [3:0] k);
    return k ^ (k >> 1);
  endfunction

endpackage

// File: rtl/hf_sync2.sv
// rtl/hf_sync2.sv - two-flop synchronizer for a single asynchronous bit
//
// Purpose : brings the function block output into the clk domain.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset, output resets to 0
//           i_d   - asynchronous input bit
//           o_q   - synchronized output bit

module hf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hf_func_sequencer.sv
// rtl/hf_func_sequencer.sv - Gray-order exerciser and checker for a 4-input function block
//
// Purpose : steps {A,B,C,D} through all 16 codes in Gray order, waits a
//           programmable settle window per code, samples the synchronized F
//           and compares it against EXP_TT. Reports mismatch map and verdict.
//           Optional glitch monitor enabled by defining HF_GLITCH_MON_EN.
// Ports   : clk           - system clock, rising edge
//           rst_n         - asynchronous active-low reset
//           start         - level, accepted in IDLE only
//           settle_cycles - hold time per code, latched at start (0 acts as 1)
//           f_in          - F from the function block, asynchronous to clk
//           abcd          - {A,B,C,D} driven to the function block
//           busy          - sweep in progress
//           done          - one-cycle pulse at sweep end
//           pass          - verdict of the last sweep
//           err_cnt       - number of mismatching codes
//           fail_vec      - bit i set when code i mismatched
//           glitch_cnt    - number of codes that glitched (0 without monitor)
//           glitch_vec    - bit i set when code i glitched (0 without monitor)

module hf_func_sequencer
  import hf_seq_pkg::*;
#(
  parameter int          SETTLE_W = 8,
  parameter logic [15:0] EXP_TT   = HF_EXP_TT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                f_in,
  output logic [3:0]          abcd,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [4:0]          err_cnt,
  output logic [15:0]         fail_vec,
  output logic [4:0]          glitch_cnt,
  output logic [15:0]         glitch_vec
);

  // One extra bit so set_eff plus the synchronizer latency never overflows.
  localparam int             CNT_W        = SETTLE_W + 1;
  localparam logic [CNT_W-1:0] LP_CNT_EXTRA = CNT_W'(HF_SYNC_STAGES - 1);

  hf_state_e           r_state;
  hf_state_e           w_state_nxt;
  logic [3:0]          r_step,    w_step_nxt;
  logic [3:0]          r_abcd,    w_abcd_nxt;
  logic [SETTLE_W-1:0] r_set_eff, w_set_eff_nxt;
  logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
  logic                r_busy,    w_busy_nxt;
  logic                r_done,    w_done_nxt;
  logic                r_pass,    w_pass_nxt;
  logic [4:0]          r_err_cnt, w_err_nxt;
  logic [15:0]         r_fail_vec, w_fail_nxt;

  logic                w_f_sync;
  logic [SETTLE_W-1:0] w_set_eff_in;
  logic                w_cnt_last;
  logic                w_mismatch;
  logic                w_glitch_any;

  hf_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (f_in),
    .o_q   (w_f_sync)
  );

  assign w_set_eff_in = (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
  // SETTLE lasts set_eff + HF_SYNC_STAGES cycles; counter starts at 0.
  assign w_cnt_last   = (r_cnt == ({1'b0, r_set_eff} + LP_CNT_EXTRA));
  assign w_mismatch   = (w_f_sync != EXP_TT[r_abcd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_abcd_nxt    = r_abcd;
    w_set_eff_nxt = r_set_eff;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_pass_nxt    = r_pass;
    w_err_nxt     = r_err_cnt;
    w_fail_nxt    = r_fail_vec;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_set_eff_nxt = w_set_eff_in;
          w_step_nxt    = 4'd0;
          w_abcd_nxt    = gray4(4'd0);
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_pass_nxt    = 1'b0;
          w_err_nxt     = 5'd0;
          w_fail_nxt    = 16'd0;
          w_state_nxt   = SETTLE;
        end
      end
      SETTLE: begin
        if (w_cnt_last) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      SAMPLE: begin
        // 16 codes at most one error each, so the 5-bit count cannot wrap.
        w_err_nxt          = r_err_cnt + {4'd0, w_mismatch};
        w_fail_nxt[r_abcd] = r_fail_vec[r_abcd] | w_mismatch;
        if (r_step == 4'd15) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == 5'd0) && !w_glitch_any;
          w_state_nxt = DONE;
        end else begin
          w_step_nxt  = r_step + 4'd1;
          w_abcd_nxt  = gray4(r_step + 4'd1);
          w_cnt_nxt   = '0;
          w_state_nxt = SETTLE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step     <= 4'd0;
      r_abcd     <= 4'd0;
      r_set_eff  <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= 5'd0;
      r_fail_vec <= 16'd0;
    end else begin
      r_step     <= w_step_nxt;
      r_abcd     <= w_abcd_nxt;
      r_set_eff  <= w_set_eff_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_err_cnt  <= w_err_nxt;
      r_fail_vec <= w_fail_nxt;
    end
  end

`ifdef HF_GLITCH_MON_EN
  // Transition counter per vector window (SETTLE entry through SAMPLE).
  // Saturates at 2 since only "more than one" matters.
  logic        r_f_prev;
  logic [1:0]  r_trans;
  logic [4:0]  r_glitch_cnt;
  logic [15:0] r_glitch_vec;
  logic        w_toggle;
  logic        w_glitch_hit;

  assign w_toggle     = w_f_sync ^ r_f_prev;
  assign w_glitch_hit = (r_state == SAMPLE) &&
                        ((r_trans == 2'd2) || ((r_trans == 2'd1) && w_toggle));
  assign w_glitch_any = (r_glitch_cnt != 5'd0) || w_glitch_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_prev     <= 1'b0;
      r_trans      <= 2'd0;
      r_glitch_cnt <= 5'd0;
      r_glitch_vec <= 16'd0;
    end else begin
      r_f_prev <= w_f_sync;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_trans      <= 2'd0;
            r_glitch_cnt <= 5'd0;
            r_glitch_vec <= 16'd0;
          end
        end
        SETTLE: begin
          if (w_toggle && (r_trans != 2'd2)) begin
            r_trans <= r_trans + 2'd1;
          end
        end
        SAMPLE: begin
          r_trans <= 2'd0;
          if (w_glitch_hit) begin
            r_glitch_cnt         <= r_glitch_cnt + 5'd1;
            r_glitch_vec[r_abcd] <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign glitch_cnt = r_glitch_cnt;
  assign glitch_vec = r_glitch_vec;
`else
  assign w_glitch_any = 1'b0;
  assign glitch_cnt   = 5'd0;
  assign glitch_vec   = 16'd0;
`endif

  assign abcd     = r_abcd;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign fail_vec = r_fail_vec;

endmodule

// File: doc/hf_func_sequencer.md
# hf_func_sequencer

Self-checking sequencer for the 4-input hazard-free combinational function F = (~A & ~D) | ((A | B) & (~B | ~C)).
- Drives A/B/C/D through all 16 input codes in Gray order, so exactly one input changes per step.
- Holds each code for a programmable settle window, samples the returned F and compares it with the expected truth table.
- Reports the per-vector mismatch map and a pass/fail verdict.
- Sits between the function block and board-level control/LED logic.

## Interface
- SETTLE_W, 8, width of settle-cycle count
- EXP_TT, 16'h3F75, expected F; bit i = F for {A,B,C,D} = i, A is MSB
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; sampled in IDLE only, starts a sweep
- settle_cycles  in  SETTLE_W  hold time per vector; latched at start
- f_in  in  1  F output of the function block; asynchronous to clk
- abcd  out  4  {A,B,C,D} driven to the function block, registered
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  verdict of the last sweep, held until the next start
- err_cnt  out  5  number of mismatching vectors, 0..16
- fail_vec  out  16  bit i set if code i mismatched
- glitch_cnt  out  5  glitching vectors (see Configuration)
- glitch_vec  out  16  bit i set if code i glitched

## Operation
- Reset values: abcd=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, glitch_cnt=0, glitch_vec=0, state IDLE.
- f_in passes through a 2-flop synchronizer to give f_sync.
- Effective settle count: set_eff = max(settle_cycles, 1).
- FSM states and transitions:
  - IDLE: on start, latch set_eff, step=0, clear err_cnt/fail_vec/glitch_*, pass=0, abcd=gray(0), go to SETTLE.
  - SETTLE: counter runs for set_eff+2 cycles (the +2 covers the synchronizer), then go to SAMPLE.
  - SAMPLE: if f_sync != EXP_TT[abcd], increment err_cnt and set fail_vec[abcd]. If step==15, go to DONE. Otherwise step++, abcd=gray(step), go to SETTLE.
  - DONE: done=1 for one cycle, pass=(err_cnt==0 && glitch_cnt==0), go to IDLE.
- gray(k) = k ^ (k>>1); the step counter is 4 bits.
- abcd holds its last code (gray(15)=4'b1000) after the sweep.
- start while busy is ignored. Holding start high in IDLE restarts immediately after DONE.
- rst_n asserted mid-sweep: all outputs return to reset values at once; no partial results are kept.
- err_cnt saturates naturally at 16 and cannot wrap.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycle 1: abcd=gray(0) valid and busy=1.
- Each vector occupies set_eff+3 cycles: set_eff+2 in SETTLE, 1 in SAMPLE.
- SAMPLE of step k falls at cycle (k+1)(set_eff+3).
- done pulses at cycle 16(set_eff+3)+1, with busy=0 in the same cycle.
- pass, err_cnt and fail_vec are final when done is high.

## Configuration
- HF_GLITCH_MON_EN defined:
  - Counts f_sync transitions per vector window, from entry to SETTLE through SAMPLE inclusive.
  - More than one transition marks a glitch: set glitch_vec[abcd] and increment glitch_cnt, at most once per vector.
  - A glitch forces pass=0.
- HF_GLITCH_MON_EN undefined: glitch_cnt and glitch_vec are tied to 0 and pass depends on err_cnt only. Ports are present in both builds.

## Structure
- Package hf_seq_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE)
  - HF_EXP_TT_DEFAULT = 16'h3F75
  - gray4() function
  - HF_SYNC_STAGES = 2
- One sub-module, hf_sync2: 2-flop synchronizer with async active-low reset, reset value 0.

## Test plan
- Reset: rst_n=0 with random inputs -> all outputs at reset values. Release, no start -> state remains IDLE, abcd=0.
- Zero-delay correct model on f_in, settle_cycles=4, start -> abcd visits 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8. done at cycle 113, pass=1, err_cnt=0, fail_vec=0.
- f_in stuck at 1, settle_cycles=4 -> err_cnt=5, fail_vec=16'hC08A, pass=0.
- settle_cycles=0 -> behaves as 1, done at cycle 65, pass=1 with the correct model.
- start re-pulsed at cycle 20 -> ignored, done still at 113. Separately, rst_n low at cycle 40 -> immediate reset values; a new start gives a clean pass.
- HF_GLITCH_MON_EN, correct model plus a 2-cycle low pulse injected on f_in mid-window of step 3 (abcd=2) -> glitch_cnt=1, glitch_vec=16'h0004, err_cnt=0, pass=0.
